// File: rtl/multi_blink_pkg.sv
// ----------------------------------------------------------------------------
// multi_blink_pkg
// Shared definitions for the multi-channel blink generator:
//   - MODE_* : encoding of the cfg_mode field
//   - ch_state_e : per-channel FSM state
//   - clamp_min1 : maps a length of 0 to 1 (zero-length phases run one tick)
// Optional build macro used by the users of this package: MULTI_BLINK_SYNC_EN.
// ----------------------------------------------------------------------------
package multi_blink_pkg;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_SOLID = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_BURST = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StSolid,
        StPhOn,
        StPhOff
    } ch_state_e;

    // Callers zero-extend narrower fields to 32 bits and truncate the result back.
    function automatic logic [31:0] clamp_min1(input logic [31:0] value);
        return (value == 32'd0) ? 32'd1 : value;
    endfunction

endpackage

// File: rtl/multi_blink_generator_if.sv
// ----------------------------------------------------------------------------
// multi_blink_generator_if
// Configuration write port of the multi-channel blink generator.
//   cfg_valid / cfg_ready : write handshake, one write per cycle when both high
//   cfg_ch                : target channel index
//   cfg_mode              : 0 OFF, 1 SOLID, 2 BLINK, 3 BURST
//   cfg_on_ticks          : on-phase length in base ticks
//   cfg_off_ticks         : off-phase length in base ticks
//   cfg_burst             : flash count for BURST
//   cfg_err               : one-cycle pulse after a write to a non-existent channel
// Modports: master (configuring FSM), slave (blink generator).
// ----------------------------------------------------------------------------
interface multi_blink_generator_if #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned BURST_W = 8
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic               cfg_valid;
    logic               cfg_ready;
    logic [CH_W-1:0]    cfg_ch;
    logic [1:0]         cfg_mode;
    logic [CNT_W-1:0]   cfg_on_ticks;
    logic [CNT_W-1:0]   cfg_off_ticks;
    logic [BURST_W-1:0] cfg_burst;
    logic               cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_on_ticks, cfg_off_ticks, cfg_burst,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_on_ticks, cfg_off_ticks, cfg_burst,
        output cfg_ready, cfg_err
    );

endinterface

// File: rtl/blink_channel.sv
// ----------------------------------------------------------------------------
// blink_channel
// One output channel: FSM (IDLE / SOLID / PH_ON / PH_OFF) with a phase counter
// counting base ticks and a burst counter counting completed flashes.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   base_tick      : shared prescaler tick
//   load           : accepted write for this channel (sampled config below)
//   sync           : realign strobe (only with MULTI_BLINK_SYNC_EN defined)
//   mode, on_ticks, off_ticks, burst : configuration fields
//   blink_out      : registered lamp output (SOLID or PH_ON)
//   busy           : registered, channel not IDLE
//   burst_done     : registered one-cycle pulse when the last flash ends
// ----------------------------------------------------------------------------
module blink_channel
    import multi_blink_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned BURST_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               base_tick,
    input  logic               load,
`ifdef MULTI_BLINK_SYNC_EN
    input  logic               sync,
`endif
    input  logic [1:0]         mode,
    input  logic [CNT_W-1:0]   on_ticks,
    input  logic [CNT_W-1:0]   off_ticks,
    input  logic [BURST_W-1:0] burst,
    output logic               blink_out,
    output logic               busy,
    output logic               burst_done
);

    ch_state_e          state_q, state_d;
    logic [CNT_W-1:0]   phase_cnt_q, phase_cnt_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0]   on_len_q, on_len_d;
    logic [CNT_W-1:0]   off_len_q, off_len_d;
    logic [1:0]         mode_q, mode_d;
    logic               done_d;
    logic               blink_q, blink_d;
    logic               busy_q, busy_d;
    logic               done_q;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            phase_cnt_q <= '0;
            burst_cnt_q <= '0;
            on_len_q    <= CNT_W'(1);
            off_len_q   <= CNT_W'(1);
            mode_q      <= MODE_OFF;
            blink_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            on_len_q    <= on_len_d;
            off_len_q   <= off_len_d;
            mode_q      <= mode_d;
            blink_q     <= blink_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state: a write beats sync, which beats the tick-driven phase advance.
    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        burst_cnt_d = burst_cnt_q;
        on_len_d    = on_len_q;
        off_len_d   = off_len_q;
        mode_d      = mode_q;
        done_d      = 1'b0;

        if (load) begin
            on_len_d    = CNT_W'(clamp_min1(32'(on_ticks)));
            off_len_d   = CNT_W'(clamp_min1(32'(off_ticks)));
            mode_d      = mode;
            burst_cnt_d = burst;
            phase_cnt_d = on_len_d;
            unique case (mode)
                MODE_OFF:   state_d = StIdle;
                MODE_SOLID: state_d = StSolid;
                MODE_BLINK: state_d = StPhOn;
                MODE_BURST: state_d = (burst == '0) ? StIdle : StPhOn;
                default:    state_d = StIdle;
            endcase
        end
`ifdef MULTI_BLINK_SYNC_EN
        else if (sync && (state_q == StPhOn || state_q == StPhOff)) begin
            state_d     = StPhOn;
            phase_cnt_d = on_len_q;
        end
`endif
        else if (base_tick) begin
            case (state_q)
                StPhOn: begin
                    if (phase_cnt_q == CNT_W'(1)) begin
                        state_d     = StPhOff;
                        phase_cnt_d = off_len_q;
                    end else begin
                        phase_cnt_d = phase_cnt_q - CNT_W'(1);
                    end
                end
                StPhOff: begin
                    if (phase_cnt_q == CNT_W'(1)) begin
                        if (mode_q == MODE_BURST) begin
                            burst_cnt_d = burst_cnt_q - BURST_W'(1);
                            if (burst_cnt_q == BURST_W'(1)) begin
                                state_d = StIdle;
                                done_d  = 1'b1;
                            end else begin
                                state_d     = StPhOn;
                                phase_cnt_d = on_len_q;
                            end
                        end else begin
                            state_d     = StPhOn;
                            phase_cnt_d = on_len_q;
                        end
                    end else begin
                        phase_cnt_d = phase_cnt_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, giving 1 clk latency.
    always_comb begin
        blink_d = (state_d == StSolid) || (state_d == StPhOn);
        busy_d  = (state_d != StIdle);
    end

    assign blink_out  = blink_q;
    assign busy       = busy_q;
    assign burst_done = done_q;

endmodule

// File: rtl/multi_blink_generator.sv
// ----------------------------------------------------------------------------
// multi_blink_generator
// NUM_CH independent lamp channels (OFF / SOLID / BLINK / BURST) sharing one
// free-running prescaler that produces the base tick.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   sync_pulse   : realigns all blinking channels and clears the prescaler
//                  (present only when MULTI_BLINK_SYNC_EN is defined)
//   cfg          : configuration write port (multi_blink_generator_if.slave)
//   blink_out    : registered lamp outputs, one per channel
//   busy         : channel is in SOLID, PH_ON or PH_OFF
//   burst_done   : one-cycle pulse per channel when a burst completes
// Optional build macro: MULTI_BLINK_SYNC_EN.
// ----------------------------------------------------------------------------
module multi_blink_generator
    import multi_blink_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned BURST_W  = 8,
    parameter int unsigned PRESCALE = 50_000
) (
    input  logic                  clk,
    input  logic                  reset_n,
`ifdef MULTI_BLINK_SYNC_EN
    input  logic                  sync_pulse,
`endif
    multi_blink_generator_if.slave cfg,
    output logic [NUM_CH-1:0]     blink_out,
    output logic [NUM_CH-1:0]     busy,
    output logic [NUM_CH-1:0]     burst_done
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    // Prescaler: counts 0..PRESCALE-1; the tick is the wrap cycle.
    logic [PS_W-1:0] prescale_q, prescale_d;
    logic            base_tick;

    assign base_tick = (prescale_q == PS_W'(PRESCALE - 1));

    always_comb begin
        prescale_d = base_tick ? '0 : prescale_q + PS_W'(1);
`ifdef MULTI_BLINK_SYNC_EN
        if (sync_pulse) begin
            prescale_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale_q <= '0;
        end else begin
            prescale_q <= prescale_d;
        end
    end

    // Write decode
    logic accept;
    logic ch_ok;
    logic err_q;

    assign cfg.cfg_ready = reset_n;
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;
    // One extra bit so NUM_CH itself is representable when it is a power of two.
    assign ch_ok         = {1'b0, cfg.cfg_ch} < (CH_W + 1)'(NUM_CH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && !ch_ok;
        end
    end

    assign cfg.cfg_err = err_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic load;

        assign load = accept && ch_ok && (cfg.cfg_ch == CH_W'(i));

        blink_channel #(
            .CNT_W   (CNT_W),
            .BURST_W (BURST_W)
        ) u_channel (
            .clk        (clk),
            .reset_n    (reset_n),
            .base_tick  (base_tick),
            .load       (load),
`ifdef MULTI_BLINK_SYNC_EN
            .sync       (sync_pulse),
`endif
            .mode       (cfg.cfg_mode),
            .on_ticks   (cfg.cfg_on_ticks),
            .off_ticks  (cfg.cfg_off_ticks),
            .burst      (cfg.cfg_burst),
            .blink_out  (blink_out[i]),
            .busy       (busy[i]),
            .burst_done (burst_done[i])
        );
    end

endmodule

// File: tb/tb_multi_blink_generator.sv
// ----------------------------------------------------------------------------
// tb_multi_blink_generator
// Two instances (PRESCALE 1 and 4) receive identical configuration writes.
// A reference model derives each channel's expected outputs from the write
// time and the number of base ticks elapsed since then, and queues one
// expectation per cycle; a monitor pops and compares on the falling edge.
// ----------------------------------------------------------------------------
module tb_multi_blink_generator;

    localparam int NUM_CH  = 5;
    localparam int CNT_W   = 16;
    localparam int BURST_W = 8;

    typedef struct {
        int mode;
        int on;
        int off;
        int burst;
        int w;
    } rec_t;

    typedef struct {
        logic [NUM_CH-1:0] blink;
        logic [NUM_CH-1:0] busy;
        logic [NUM_CH-1:0] done;
        logic              err;
    } exp_t;

    logic clk;
    logic reset_n;

    logic               drv_valid;
    logic [2:0]         drv_ch;
    logic [1:0]         drv_mode;
    logic [CNT_W-1:0]   drv_on;
    logic [CNT_W-1:0]   drv_off;
    logic [BURST_W-1:0] drv_burst;

    logic [NUM_CH-1:0] blink_p1, busy_p1, done_p1;
    logic [NUM_CH-1:0] blink_p4, busy_p4, done_p4;

    int checks = 0;
    int errors = 0;

    rec_t rec [NUM_CH];
    exp_t q [2][$];
    int   cyc = 0;

    multi_blink_generator_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .BURST_W(BURST_W)) cfg_p1 ();
    multi_blink_generator_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .BURST_W(BURST_W)) cfg_p4 ();

    assign cfg_p1.cfg_valid     = drv_valid;
    assign cfg_p1.cfg_ch        = drv_ch;
    assign cfg_p1.cfg_mode      = drv_mode;
    assign cfg_p1.cfg_on_ticks  = drv_on;
    assign cfg_p1.cfg_off_ticks = drv_off;
    assign cfg_p1.cfg_burst     = drv_burst;
    assign cfg_p4.cfg_valid     = drv_valid;
    assign cfg_p4.cfg_ch        = drv_ch;
    assign cfg_p4.cfg_mode      = drv_mode;
    assign cfg_p4.cfg_on_ticks  = drv_on;
    assign cfg_p4.cfg_off_ticks = drv_off;
    assign cfg_p4.cfg_burst     = drv_burst;

    multi_blink_generator #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .BURST_W(BURST_W), .PRESCALE(1)
    ) dut_p1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg        (cfg_p1),
        .blink_out  (blink_p1),
        .busy       (busy_p1),
        .burst_done (done_p1)
    );

    multi_blink_generator #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .BURST_W(BURST_W), .PRESCALE(4)
    ) dut_p4 (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg        (cfg_p4),
        .blink_out  (blink_p4),
        .busy       (busy_p4),
        .burst_done (done_p4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int d, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got %h want %h", name, d, $time, got, want);
        end
    endtask

    function automatic int prescale_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic rec_t make_rec(input int mode, input int on, input int off,
                                      input int burst, input int w);
        rec_t r;
        r.mode  = (mode == 3 && burst == 0) ? 0 : mode;
        r.on    = (on == 0) ? 1 : on;
        r.off   = (off == 0) ? 1 : off;
        r.burst = burst;
        r.w     = w;
        return r;
    endfunction

    // Base ticks fall in cycles x with x % p == p-1; t counts those in [w+1, c-1].
    function automatic void chan_exp(input rec_t r, input int c, input int p,
                                     output logic b, output logic bs, output logic dn);
        int t, t_prev, per, tot;
        b  = 1'b0;
        bs = 1'b0;
        dn = 1'b0;
        per    = r.on + r.off;
        t      = c / p - (r.w + 1) / p;
        t_prev = (c - 1) / p - (r.w + 1) / p;
        case (r.mode)
            1: begin
                b  = 1'b1;
                bs = 1'b1;
            end
            2: begin
                b  = (t % per) < r.on;
                bs = 1'b1;
            end
            3: begin
                tot = r.burst * per;
                if (t < tot) begin
                    b  = (t % per) < r.on;
                    bs = 1'b1;
                end else if (t == tot && t_prev == tot - 1) begin
                    dn = 1'b1;
                end
            end
            default: ;
        endcase
    endfunction

    // Reference model: one expectation per cycle per instance.
    initial begin
        exp_t e;
        logic b, bs, dn;
        logic exp_err;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                for (int ch = 0; ch < NUM_CH; ch++) rec[ch] = make_rec(0, 1, 1, 0, 0);
                cyc = 0;
                e.blink = '0;
                e.busy  = '0;
                e.done  = '0;
                e.err   = 1'b0;
                q[0].push_back(e);
                q[1].push_back(e);
            end else begin
                exp_err = 1'b0;
                if (drv_valid) begin
                    if (int'(drv_ch) < NUM_CH) begin
                        rec[drv_ch] = make_rec(int'(drv_mode), int'(drv_on), int'(drv_off),
                                               int'(drv_burst), cyc);
                    end else begin
                        exp_err = 1'b1;
                    end
                end
                cyc++;
                for (int d = 0; d < 2; d++) begin
                    e.err = exp_err;
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        chan_exp(rec[ch], cyc, prescale_of(d), b, bs, dn);
                        e.blink[ch] = b;
                        e.busy[ch]  = bs;
                        e.done[ch]  = dn;
                    end
                    q[d].push_back(e);
                end
            end
        end
    end

    task automatic compare_one(input int d, input logic [NUM_CH-1:0] blink,
                               input logic [NUM_CH-1:0] busy, input logic [NUM_CH-1:0] done,
                               input logic err, input logic ready);
        exp_t e;
        check("cfg_ready", d, 32'(ready), 32'(reset_n));
        if (q[d].size() == 0) begin
            check("scoreboard_underflow", d, 32'(q[d].size()), 32'd1);
        end else begin
            e = q[d].pop_front();
            if (!reset_n) begin
                e.blink = '0;
                e.busy  = '0;
                e.done  = '0;
                e.err   = 1'b0;
            end
            check("blink_out", d, 32'(blink), 32'(e.blink));
            check("busy", d, 32'(busy), 32'(e.busy));
            check("burst_done", d, 32'(done), 32'(e.done));
            check("cfg_err", d, 32'(err), 32'(e.err));
        end
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            compare_one(0, blink_p1, busy_p1, done_p1, cfg_p1.cfg_err, cfg_p1.cfg_ready);
            compare_one(1, blink_p4, busy_p4, done_p4, cfg_p4.cfg_err, cfg_p4.cfg_ready);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write(input int ch, input int mode, input int on, input int off,
                         input int burst);
        drv_valid = 1'b1;
        drv_ch    = 3'(ch);
        drv_mode  = 2'(mode);
        drv_on    = CNT_W'(on);
        drv_off   = CNT_W'(off);
        drv_burst = BURST_W'(burst);
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_blink"}, 0, 32'(blink_p1), 32'd0);
        check({name, "_busy"}, 0, 32'(busy_p1), 32'd0);
        check({name, "_done"}, 0, 32'(done_p1), 32'd0);
        check({name, "_err"}, 0, 32'(cfg_p1.cfg_err), 32'd0);
        check({name, "_ready"}, 0, 32'(cfg_p1.cfg_ready), 32'd0);
        check({name, "_blink"}, 1, 32'(blink_p4), 32'd0);
        check({name, "_busy"}, 1, 32'(busy_p4), 32'd0);
        check({name, "_done"}, 1, 32'(done_p4), 32'd0);
        check({name, "_err"}, 1, 32'(cfg_p4.cfg_err), 32'd0);
        check({name, "_ready"}, 1, 32'(cfg_p4.cfg_ready), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        drv_valid = 1'b0;
        drv_ch    = '0;
        drv_mode  = '0;
        drv_on    = '0;
        drv_off   = '0;
        drv_burst = '0;
        #1;
        check_all_zero("reset");
        idle(3);
        reset_n = 1'b1;
        idle(2);

        write(0, 2, 3, 2, 0);       // BLINK 3/2
        idle(12);
        write(1, 3, 2, 1, 3);       // BURST 2/1 x3
        idle(14);
        write(5, 1, 1, 1, 0);       // non-existent channel
        idle(3);
        write(2, 2, 3, 3, 0);       // BLINK, then SOLID mid-phase, then OFF
        idle(5);
        write(2, 1, 0, 0, 0);
        idle(4);
        write(2, 0, 0, 0, 0);
        idle(3);
        write(4, 2, 0, 0, 0);       // zero lengths act as 1/1
        idle(20);
        write(3, 3, 1, 1, 0);       // BURST with zero flashes acts as OFF
        idle(4);

        for (int i = 0; i < 400; i++) begin
            drv_valid = ($urandom_range(0, 2) == 0);
            drv_ch    = 3'($urandom_range(0, 7));
            drv_mode  = 2'($urandom_range(0, 3));
            drv_on    = CNT_W'($urandom_range(0, 5));
            drv_off   = CNT_W'($urandom_range(0, 5));
            drv_burst = BURST_W'($urandom_range(0, 3));
            @(posedge clk);
            #1;
        end
        drv_valid = 1'b0;
        idle(10);

        // Asynchronous reset in the middle of a burst
        write(3, 3, 3, 3, 5);
        idle(6);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        idle(2);
        reset_n = 1'b1;
        idle(1);
        write(0, 2, 2, 2, 0);
        write(1, 3, 1, 2, 2);
        idle(20);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
